// File: rtl/register_status_table_if.sv
// Dispatcher/CDB-side bundle of the register status table: read ports,
// rename request, CDB snoop, flush and the pending summary.
interface register_status_table_if #(
  parameter int NREGS = 32
) ();
  localparam int AW = $clog2(NREGS);
  localparam int CW = $clog2(NREGS) + 1;

  logic          en;
  logic          cdb_valid;
  logic [31:0]   cdb_data;
  logic [7:0]    cdb_tag;
  logic [AW-1:0] rd_addr_a;
  logic [AW-1:0] rd_addr_b;
  logic [31:0]   rd_val_a;
  logic [31:0]   rd_val_b;
  logic [7:0]    rd_tag_a;
  logic [7:0]    rd_tag_b;
  logic          rename_en;
  logic [AW-1:0] rename_addr;
  logic [7:0]    rename_tag;
  logic          flush;
  logic [CW-1:0] pending_count;
  logic          all_clear;

  modport master (
    output en, cdb_valid, cdb_data, cdb_tag, rd_addr_a, rd_addr_b,
           rename_en, rename_addr, rename_tag, flush,
    input  rd_val_a, rd_val_b, rd_tag_a, rd_tag_b, pending_count, all_clear
  );

  modport slave (
    input  en, cdb_valid, cdb_data, cdb_tag, rd_addr_a, rd_addr_b,
           rename_en, rename_addr, rename_tag, flush,
    output rd_val_a, rd_val_b, rd_tag_a, rd_tag_b, pending_count, all_clear
  );
endinterface

// File: rtl/register_status_table.sv
// Architectural register file with producer tags: operands read as value or
// pending tag, destinations renamed, CDB broadcasts retire matching tags.
module register_status_table #(
  parameter int NREGS = 32
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  register_status_table_if.slave    bus
);
  localparam int AW = $clog2(NREGS);
  localparam int CW = $clog2(NREGS) + 1;

  logic [31:0]    r_value [NREGS];
  logic [7:0]     r_tag   [NREGS];
  logic [CW-1:0]  r_pending;

  logic [31:0]    w_value_nxt [NREGS];
  logic [7:0]     w_tag_nxt   [NREGS];
  logic [NREGS-1:0] w_pend_nxt;
  logic           w_cdb_live;
  logic           w_rename_live;

  assign w_cdb_live    = bus.en & bus.cdb_valid & bus.cdb_tag[7];
  assign w_rename_live = bus.en & bus.rename_en & bus.rename_tag[7] &
                         (bus.rename_addr != {AW{1'b0}});

  function automatic logic [CW-1:0] f_popcount(input logic [NREGS-1:0] v);
    logic [CW-1:0] n;
    n = {CW{1'b0}};
    for (int i = 0; i < NREGS; i++) begin
      n = n + {{(CW-1){1'b0}}, v[i]};
    end
    return n;
  endfunction

  // Operand lookup: the CDB bypass turns a pending tag into the broadcast value.
  function automatic logic [39:0] f_read(
    input logic [AW-1:0] a,
    input logic [7:0]    t,
    input logic [31:0]   v,
    input logic          live,
    input logic [7:0]    ct,
    input logic [31:0]   cd
  );
    logic [39:0] res;
    if (a == {AW{1'b0}}) begin
      res = 40'd0;
    end else if (t[7] && live && (ct == t)) begin
      res = {cd, 8'd0};
    end else if (t[7]) begin
      res = {32'd0, t};
    end else begin
      res = {v, 8'd0};
    end
    return res;
  endfunction

  // Next state: flush clears tags; otherwise CDB retirement, then rename on top.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      logic w_hit;
      logic w_ren_hit;
      w_hit     = w_cdb_live && r_tag[i][7] && (r_tag[i] == bus.cdb_tag);
      w_ren_hit = w_rename_live && (bus.rename_addr == AW'(i));
      w_value_nxt[i] = r_value[i];
      w_tag_nxt[i]   = r_tag[i];
      if (i == 0) begin
        w_value_nxt[i] = 32'd0;
        w_tag_nxt[i]   = 8'd0;
      end else if (bus.flush) begin
        w_tag_nxt[i]   = 8'd0;
      end else begin
        w_value_nxt[i] = w_hit ? bus.cdb_data : r_value[i];
        w_tag_nxt[i]   = w_ren_hit ? bus.rename_tag : (w_hit ? 8'd0 : r_tag[i]);
      end
      w_pend_nxt[i] = w_tag_nxt[i][7];
    end
  end

  // State registers and the pending summary computed from next-state tags.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NREGS; i++) begin
        r_value[i] <= 32'd0;
        r_tag[i]   <= 8'd0;
      end
      r_pending <= {CW{1'b0}};
    end else begin
      r_value   <= w_value_nxt;
      r_tag     <= w_tag_nxt;
      r_pending <= f_popcount(w_pend_nxt);
    end
  end

  assign {bus.rd_val_a, bus.rd_tag_a} = f_read(bus.rd_addr_a, r_tag[bus.rd_addr_a],
                                               r_value[bus.rd_addr_a], w_cdb_live,
                                               bus.cdb_tag, bus.cdb_data);
  assign {bus.rd_val_b, bus.rd_tag_b} = f_read(bus.rd_addr_b, r_tag[bus.rd_addr_b],
                                               r_value[bus.rd_addr_b], w_cdb_live,
                                               bus.cdb_tag, bus.cdb_data);
  assign bus.pending_count = r_pending;
  assign bus.all_clear     = (r_pending == {CW{1'b0}});
endmodule

// File: tb/tb_register_status_table.sv
// Directed scenarios plus randomized traffic against an array-based model.
module tb_register_status_table;
  localparam int NREGS = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  register_status_table_if #(.NREGS(NREGS)) bus ();
  register_status_table #(.NREGS(NREGS)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] m_val [NREGS];
  logic [7:0]  m_tag [NREGS];

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, obs, exp, $time);
    end
  endtask

  task automatic idle();
    reset         = 1'b0;
    bus.en        = 1'b1;
    bus.cdb_valid = 1'b0;
    bus.cdb_data  = 32'd0;
    bus.cdb_tag   = 8'd0;
    bus.rename_en = 1'b0;
    bus.rename_addr = 5'd0;
    bus.rename_tag  = 8'd0;
    bus.flush     = 1'b0;
  endtask

  function automatic logic [39:0] model_read(input int a);
    if (a == 0) return 40'd0;
    if (m_tag[a][7] && bus.en && bus.cdb_valid && bus.cdb_tag[7] && bus.cdb_tag == m_tag[a])
      return {bus.cdb_data, 8'd0};
    if (m_tag[a][7]) return {32'd0, m_tag[a]};
    return {m_val[a], 8'd0};
  endfunction

  function automatic int model_pending();
    int n = 0;
    for (int i = 1; i < NREGS; i++) n += int'(m_tag[i][7]);
    return n;
  endfunction

  task automatic model_edge();
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin m_val[i] = 32'd0; m_tag[i] = 8'd0; end
    end else if (bus.flush) begin
      for (int i = 0; i < NREGS; i++) m_tag[i] = 8'd0;
    end else if (bus.en) begin
      if (bus.cdb_valid && bus.cdb_tag[7]) begin
        for (int i = 1; i < NREGS; i++) begin
          if (m_tag[i] == bus.cdb_tag) begin m_val[i] = bus.cdb_data; m_tag[i] = 8'd0; end
        end
      end
      if (bus.rename_en && bus.rename_tag[7] && bus.rename_addr != 5'd0)
        m_tag[bus.rename_addr] = bus.rename_tag;
    end
  endtask

  task automatic tick();
    int pend;
    #1;
    pend = model_pending();
    chk("port_a", {bus.rd_val_a, bus.rd_tag_a}, model_read(int'(bus.rd_addr_a)));
    chk("port_b", {bus.rd_val_b, bus.rd_tag_b}, model_read(int'(bus.rd_addr_b)));
    chk("pending_count", 64'(bus.pending_count), 64'(pend));
    chk("all_clear", 64'(bus.all_clear), 64'(pend == 0));
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  function automatic logic [7:0] rand_tag();
    logic [7:0] t;
    t = {(($urandom % 5) != 0), 4'd0, 3'($urandom % 8)};
    return t;
  endfunction

  initial begin
    idle();
    reset = 1'b1;
    bus.rd_addr_a = 5'd0;
    bus.rd_addr_b = 5'd0;
    for (int i = 0; i < NREGS; i++) begin m_val[i] = 32'd0; m_tag[i] = 8'd0; end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state
    bus.rd_addr_a = 5'd5; bus.rd_addr_b = 5'd0;
    #1;
    chk("rst_val_a", bus.rd_val_a, 32'd0);
    chk("rst_tag_a", bus.rd_tag_a, 8'd0);
    chk("rst_val_b", bus.rd_val_b, 32'd0);
    chk("rst_tag_b", bus.rd_tag_b, 8'd0);
    chk("rst_pending", bus.pending_count, 6'd0);
    chk("rst_all_clear", bus.all_clear, 1'b1);
    tick();

    // Rename r3 then retire via CDB with bypass
    bus.rd_addr_a = 5'd3;
    bus.rename_en = 1'b1; bus.rename_addr = 5'd3; bus.rename_tag = 8'hC2;
    tick();
    idle(); #1;
    chk("r3_tag", bus.rd_tag_a, 8'hC2);
    chk("r3_val_pend", bus.rd_val_a, 32'd0);
    chk("r3_pending", bus.pending_count, 6'd1);
    tick();
    bus.cdb_valid = 1'b1; bus.cdb_tag = 8'hC2; bus.cdb_data = 32'h1234; #1;
    chk("r3_bypass_val", bus.rd_val_a, 32'h1234);
    chk("r3_bypass_tag", bus.rd_tag_a, 8'd0);
    tick();
    idle(); #1;
    chk("r3_stored", bus.rd_val_a, 32'h1234);
    chk("r3_pending0", bus.pending_count, 6'd0);
    tick();

    // Rename and matching broadcast together: rename wins
    bus.rd_addr_a = 5'd7;
    bus.rename_en = 1'b1; bus.rename_addr = 5'd7; bus.rename_tag = 8'h88;
    bus.cdb_valid = 1'b1; bus.cdb_tag = 8'h88; bus.cdb_data = 32'hDEAD;
    tick();
    idle(); #1;
    chk("r7_still_pend", bus.rd_tag_a, 8'h88);
    tick();
    bus.cdb_valid = 1'b1; bus.cdb_tag = 8'h88; bus.cdb_data = 32'hBEEF;
    tick();
    idle(); #1;
    chk("r7_val", {bus.rd_val_a, bus.rd_tag_a}, {32'hBEEF, 8'h00});
    tick();

    // Re-rename: old tag no longer retires the register
    bus.rd_addr_a = 5'd4;
    bus.rename_en = 1'b1; bus.rename_addr = 5'd4; bus.rename_tag = 8'hA1;
    tick();
    bus.rename_tag = 8'h90;
    tick();
    idle(); bus.cdb_valid = 1'b1; bus.cdb_tag = 8'hA1; bus.cdb_data = 32'h77;
    tick();
    idle(); #1;
    chk("r4_still_90", bus.rd_tag_a, 8'h90);
    tick();
    bus.cdb_valid = 1'b1; bus.cdb_tag = 8'h90; bus.cdb_data = 32'd5;
    tick();
    idle(); #1;
    chk("r4_val", {bus.rd_val_a, bus.rd_tag_a}, {32'd5, 8'h00});
    tick();

    // en low: no bypass, no capture; en high captures the same broadcast
    bus.rd_addr_a = 5'd2;
    bus.rename_en = 1'b1; bus.rename_addr = 5'd2; bus.rename_tag = 8'h83;
    tick();
    idle(); bus.en = 1'b0;
    bus.cdb_valid = 1'b1; bus.cdb_tag = 8'h83; bus.cdb_data = 32'h55; #1;
    chk("r2_en0_tag", bus.rd_tag_a, 8'h83);
    chk("r2_en0_val", bus.rd_val_a, 32'd0);
    tick();
    bus.en = 1'b1; #1;
    chk("r2_en1_bypass", {bus.rd_val_a, bus.rd_tag_a}, {32'h55, 8'h00});
    tick();
    idle(); #1;
    chk("r2_captured", {bus.rd_val_a, bus.rd_tag_a}, {32'h55, 8'h00});
    tick();

    // Flush keeps values, clears tags; r0 rename ignored
    bus.rename_en = 1'b1; bus.rename_addr = 5'd1; bus.rename_tag = 8'h81; tick();
    bus.rename_addr = 5'd2; bus.rename_tag = 8'h82; tick();
    bus.rename_addr = 5'd9; bus.rename_tag = 8'h89; tick();
    idle(); #1;
    chk("pre_flush_pending", bus.pending_count, 6'd3);
    bus.flush = 1'b1;
    tick();
    idle(); bus.rd_addr_a = 5'd2; bus.rd_addr_b = 5'd9; #1;
    chk("flush_r2", {bus.rd_val_a, bus.rd_tag_a}, {32'h55, 8'h00});
    chk("flush_r9", {bus.rd_val_b, bus.rd_tag_b}, {32'h0, 8'h00});
    chk("flush_pending", bus.pending_count, 6'd0);
    chk("flush_all_clear", bus.all_clear, 1'b1);
    tick();
    bus.rd_addr_a = 5'd0;
    bus.rename_en = 1'b1; bus.rename_addr = 5'd0; bus.rename_tag = 8'hC1;
    tick();
    idle(); #1;
    chk("r0_read", {bus.rd_val_a, bus.rd_tag_a}, 40'd0);
    chk("r0_pending", bus.pending_count, 6'd0);
    tick();

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      reset         = (($urandom % 150) == 0);
      bus.en        = (($urandom % 8) != 0);
      bus.flush     = (($urandom % 60) == 0);
      bus.cdb_valid = $urandom % 2;
      bus.cdb_tag   = rand_tag();
      bus.cdb_data  = $urandom;
      bus.rename_en = $urandom % 2;
      bus.rename_addr = 5'($urandom % 12);
      bus.rename_tag  = rand_tag();
      bus.rd_addr_a = 5'(($urandom % 4 == 0) ? $urandom % 32 : $urandom % 12);
      bus.rd_addr_b = 5'($urandom % 12);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/register_status_table.md
# register_status_table

Architectural register file with per-register producer tags: the consumer end of the common data bus (CDB). The dispatcher reads source operands as either a ready value or the tag of the pending producer, then renames the destination register to the tag of the unit accepting the instruction. The table snoops every CDB broadcast (memory, add, mul, div units) and retires matching tags into values. It sits between the dispatcher and the CDB, beside the reservation stations.

## Interface
- NREGS, 32, number of architectural registers; the address width is log2(NREGS) (5 at the default).
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; clears every value and tag.
- en  in  1  global enable; when low, no state changes and CDB bypass is disabled.
- cdb_valid  in  1  CDB broadcast valid.
- cdb_data  in  32  CDB result value.
- cdb_tag  in  8  producer tag {tag_valid, mem_type, add_type, mul_type, div_type, 3'dID}.
- rd_addr_a, rd_addr_b  in  5  source register addresses.
- rd_val_a, rd_val_b  out  32  operand value; 0 while pending.
- rd_tag_a, rd_tag_b  out  8  producer tag; bit 7 = 1 means pending, all-zero means the value is ready.
- rename_en  in  1  destination rename request.
- rename_addr  in  5  destination register.
- rename_tag  in  8  acceptor tag of the unit that took the instruction.
- flush  in  1  synchronous clear of all tags; values are kept.
- pending_count  out  6  registered count of registers with tag bit 7 set.
- all_clear  out  1  pending_count == 0.

## Operation
- State per register i: value[i] (32 bits) and tag[i] (8 bits). Register 0 is hardwired: it always reads value 0 and tag 0, and is never renamed or written.
- Priority at each edge: reset > flush > (en-gated rename and CDB write).
- CDB write: when en, cdb_valid and cdb_tag[7] are all set, every register i != 0 with tag[i][7]=1 and tag[i]==cdb_tag gets value[i] <= cdb_data and tag[i] <= 0. All matching registers update. A broadcast with cdb_tag[7]=0 is ignored.
- Rename: when en, rename_en and rename_tag[7] are all set and rename_addr != 0, tag[rename_addr] <= rename_tag. If rename_tag[7]=0 or rename_addr=0, the request is ignored.
- Simultaneous rename and CDB match on the same register: value takes cdb_data and tag takes rename_tag, so the rename wins.
- A rename may overwrite an already pending tag. A later broadcast of the old tag then leaves that register untouched.
- flush: all tags become 0, values are unchanged, and any rename or CDB write in that cycle is dropped.
- Read ports are combinational from the registered state, plus the same-cycle bypass below. For each port, with a = address:
  - a == 0: value 0, tag 0.
  - tag[a][7]=1, and en, cdb_valid, cdb_tag[7] are set with cdb_tag==tag[a]: bypass, value cdb_data, tag 0.
  - tag[a][7]=1 otherwise: value 0, tag tag[a].
  - else: value value[a], tag 0.
- A read returns the pre-rename state of its register in the cycle a rename of that register occurs. This gives correct results for instructions such as r1 = r1 + r2.
- pending_count: registered. Each edge it loads the popcount of the next-state tag bit 7 over registers 1..NREGS-1. all_clear is derived from it.

## Timing
- Reset values: all value[i]=0 and tag[i]=0; pending_count=0; all_clear=1. Every read output is 0 after reset.
- Rename asserted in cycle N: the new tag is visible on the read ports and in pending_count from cycle N+1.
- CDB broadcast in cycle N: a matching read sees cdb_data in cycle N through the bypass, and from the stored state in cycle N+1.
- en low in cycle N: state and pending_count hold, and there is no bypass. A unit that keeps broadcasting is captured in the first cycle with en high.
- Reset or flush asserted mid-operation takes effect at the next edge and overrides any concurrent rename or CDB write.
- There is no backpressure. Every valid CDB broadcast is consumed in its cycle when en=1.

## Test plan
- Reset, then read r5 and r0 -> 0/0 on both ports; pending_count=0; all_clear=1.
- Rename r3 with tag 0xC2, then next cycle read r3 -> val 0, tag 0xC2, pending_count=1. Broadcast tag 0xC2 with data 0x1234 -> same-cycle read gives 0x1234 with tag 0; next cycle the stored value is 0x1234 and pending_count=0.
- Rename r7 with 0x88 and broadcast 0x88 / 0xDEAD together -> r7 is still pending on 0x88. Broadcast 0x88 / 0xBEEF -> r7 = 0xBEEF.
- Rename r4 with 0xA1, then re-rename r4 with 0x90. Broadcast 0xA1 -> r4 still pending on 0x90. Broadcast 0x90 / 5 -> r4 = 5.
- With r2 pending, broadcast its tag while en=0 -> no bypass and r2 stays pending. Raise en with the same broadcast -> r2 is captured.
- Rename r1, r2 and r9, then flush -> all tags clear, prior values are kept, pending_count=0. A rename of r0 with 0xC1 -> ignored, and r0 reads 0/0.
